// File: rtl/demux_memoria_pkg.sv
// Shared defaults, lane-select constants and pointer sizing for demux_memoria.
package demux_memoria_pkg;

  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_DEPTH = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // One extra pointer bit separates "full" from "empty" when the low bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_memoria_lane_fifo.sv
// First-word-fall-through lane FIFO with a wrapping delivered-word counter.
module lane_fifo
  import demux_memoria_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign valid = !empty;
  // Stale memory is never cleared; the mask keeps it off the output.
  assign data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_memoria.sv
// 2-lane demultiplexer: steers one valid/ready stream into two lane FIFOs.
module demux_memoria
  import demux_memoria_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             selector,
  output logic             ready_in,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out0,
  output logic             valid_out1,
  input  logic             pop0,
  input  logic             pop1,
  output logic             full0,
  output logic             full1,
  output logic [CW-1:0]    count0,
  output logic [CW-1:0]    count1
);

  logic push0;
  logic push1;

  // Backpressure looks only at the selected lane's occupancy, never at a same-cycle pop.
  assign ready_in = (selector == LANE1) ? !full1 : !full0;
  assign push0    = valid_in && ready_in && (selector == LANE0);
  assign push1    = valid_in && ready_in && (selector == LANE1);

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_lane0 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push0),
    .push_data (data_in),
    .pop       (pop0),
    .data      (data_out0),
    .valid     (valid_out0),
    .full      (full0),
    .count     (count0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_lane1 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push1),
    .push_data (data_in),
    .pop       (pop1),
    .data      (data_out1),
    .valid     (valid_out1),
    .full      (full1),
    .count     (count1)
  );

endmodule

// File: tb/tb_demux_memoria.sv
// Directed-vector bench for demux_memoria plus hand-written multi-cycle corner cases.
module tb_demux_memoria;

  logic       clk;
  logic       reset_L;
  logic [1:0] data_in;
  logic       valid_in;
  logic       selector;
  logic       ready_in;
  logic [1:0] data_out0;
  logic [1:0] data_out1;
  logic       valid_out0;
  logic       valid_out1;
  logic       pop0;
  logic       pop1;
  logic       full0;
  logic       full1;
  logic [3:0] count0;
  logic [3:0] count1;

  int compared = 0;
  int mismatched = 0;

  demux_memoria dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .selector   (selector),
    .ready_in   (ready_in),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .pop0       (pop0),
    .pop1       (pop1),
    .full0      (full0),
    .full1      (full1),
    .count0     (count0),
    .count1     (count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       vin;
    logic       sel;
    logic [1:0] din;
    logic       p0;
    logic       p1;
    logic       vo0;
    logic [1:0] d0;
    logic       vo1;
    logic [1:0] d1;
    logic       f0;
    logic       f1;
    logic       rdy;
    logic [3:0] c0;
    logic [3:0] c1;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(input logic vin, input logic sel, input logic [1:0] din,
                              input logic p0, input logic p1,
                              input logic vo0, input logic [1:0] d0,
                              input logic vo1, input logic [1:0] d1,
                              input logic f0, input logic f1, input logic rdy,
                              input logic [3:0] c0, input logic [3:0] c1);
    vec_t v;
    v.vin = vin; v.sel = sel; v.din = din; v.p0 = p0; v.p1 = p1;
    v.vo0 = vo0; v.d0 = d0; v.vo1 = vo1; v.d1 = d1;
    v.f0 = f0; v.f1 = f1; v.rdy = rdy; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0;
    selector = 1'b0;
    data_in  = 2'b00;
    pop0     = 1'b0;
    pop1     = 1'b0;
  endtask

  // One clock: drive at the falling edge, let the rising edge happen, return at the next falling edge.
  task automatic step(input logic vin, input logic sel, input logic [1:0] din,
                      input logic p0, input logic p1);
    valid_in = vin; selector = sel; data_in = din; pop0 = p0; pop1 = p1;
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset_L = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  logic [1:0] wseq [10];
  logic [1:0] fill [4];

  initial begin
    reset_L = 1'b0;
    idle();

    // Steering, then lane 1 fill / backpressure / drain.
    vt[0]  = mk(1, 0, 2'b01, 0, 0,  1, 2'b01, 0, 2'b00, 0, 0, 1, 4'd0, 4'd0);
    vt[1]  = mk(1, 1, 2'b10, 0, 0,  1, 2'b01, 1, 2'b10, 0, 0, 1, 4'd0, 4'd0);
    vt[2]  = mk(1, 0, 2'b11, 0, 0,  1, 2'b01, 1, 2'b10, 0, 0, 1, 4'd0, 4'd0);
    vt[3]  = mk(0, 0, 2'b00, 1, 0,  1, 2'b11, 1, 2'b10, 0, 0, 1, 4'd1, 4'd0);
    vt[4]  = mk(0, 0, 2'b00, 1, 0,  0, 2'b00, 1, 2'b10, 0, 0, 1, 4'd2, 4'd0);
    vt[5]  = mk(0, 0, 2'b00, 0, 1,  0, 2'b00, 0, 2'b00, 0, 0, 1, 4'd2, 4'd1);
    vt[6]  = mk(1, 1, 2'b00, 0, 0,  0, 2'b00, 1, 2'b00, 0, 0, 1, 4'd2, 4'd1);
    vt[7]  = mk(1, 1, 2'b01, 0, 0,  0, 2'b00, 1, 2'b00, 0, 0, 1, 4'd2, 4'd1);
    vt[8]  = mk(1, 1, 2'b10, 0, 0,  0, 2'b00, 1, 2'b00, 0, 0, 1, 4'd2, 4'd1);
    vt[9]  = mk(1, 1, 2'b11, 0, 0,  0, 2'b00, 1, 2'b00, 0, 1, 0, 4'd2, 4'd1);
    vt[10] = mk(1, 1, 2'b00, 0, 0,  0, 2'b00, 1, 2'b00, 0, 1, 0, 4'd2, 4'd1);
    vt[11] = mk(0, 0, 2'b00, 0, 0,  0, 2'b00, 1, 2'b00, 0, 1, 1, 4'd2, 4'd1);
    vt[12] = mk(0, 0, 2'b00, 0, 1,  0, 2'b00, 1, 2'b01, 0, 0, 1, 4'd2, 4'd2);
    vt[13] = mk(0, 0, 2'b00, 0, 1,  0, 2'b00, 1, 2'b10, 0, 0, 1, 4'd2, 4'd3);
    vt[14] = mk(0, 0, 2'b00, 0, 1,  0, 2'b00, 1, 2'b11, 0, 0, 1, 4'd2, 4'd4);
    vt[15] = mk(0, 0, 2'b00, 0, 1,  0, 2'b00, 0, 2'b00, 0, 0, 1, 4'd2, 4'd5);

    wseq[0] = 2'b01; wseq[1] = 2'b11; wseq[2] = 2'b00; wseq[3] = 2'b10; wseq[4] = 2'b10;
    wseq[5] = 2'b01; wseq[6] = 2'b11; wseq[7] = 2'b00; wseq[8] = 2'b01; wseq[9] = 2'b10;
    fill[0] = 2'b10; fill[1] = 2'b11; fill[2] = 2'b01; fill[3] = 2'b00;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid_out0", valid_out0, 0);
    chk("rst.valid_out1", valid_out1, 0);
    chk("rst.data_out0", data_out0, 0);
    chk("rst.data_out1", data_out1, 0);
    chk("rst.count0", count0, 0);
    chk("rst.count1", count1, 0);
    chk("rst.full0", full0, 0);
    chk("rst.full1", full1, 0);
    chk("rst.ready_in", ready_in, 1);
    @(negedge clk);
    reset_L = 1'b1;

    for (int i = 0; i < 16; i++) begin
      valid_in = vt[i].vin; selector = vt[i].sel; data_in = vt[i].din;
      pop0 = vt[i].p0; pop1 = vt[i].p1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid_out0", i), valid_out0, vt[i].vo0);
      chk($sformatf("v%0d.data_out0", i), data_out0, vt[i].d0);
      chk($sformatf("v%0d.valid_out1", i), valid_out1, vt[i].vo1);
      chk($sformatf("v%0d.data_out1", i), data_out1, vt[i].d1);
      chk($sformatf("v%0d.full0", i), full0, vt[i].f0);
      chk($sformatf("v%0d.full1", i), full1, vt[i].f1);
      chk($sformatf("v%0d.ready_in", i), ready_in, vt[i].rdy);
      chk($sformatf("v%0d.count0", i), count0, vt[i].c0);
      chk($sformatf("v%0d.count1", i), count1, vt[i].c1);
      @(negedge clk);
      idle();
    end

    // Wrap-around on lane 0: 10 pushes, 10 pops, occupancy kept at 1..2.
    do_reset();
    begin
      int pi;
      int qi;
      pi = 0;
      qi = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
        if (cyc >= 2) begin
          chk($sformatf("wrap%0d.valid_out0", cyc), valid_out0, 1);
          chk($sformatf("wrap%0d.data_out0", cyc), data_out0, wseq[qi]);
        end
        if (cyc < 10) chk($sformatf("wrap%0d.ready_in", cyc), ready_in, 1);
        valid_in = (cyc < 10);
        selector = 1'b0;
        data_in  = (cyc < 10) ? wseq[pi] : 2'b00;
        pop0     = (cyc >= 2);
        @(posedge clk);
        @(negedge clk);
        if (cyc < 10) pi++;
        if (cyc >= 2) qi++;
        idle();
      end
    end
    chk("wrap.valid_out0_end", valid_out0, 0);
    chk("wrap.count0", count0, 10);

    // Lane 1 full with push and pop in the same cycle: push blocked, pop proceeds.
    for (int i = 0; i < 4; i++) step(1, 1, fill[i], 0, 0);
    valid_in = 1'b1; selector = 1'b1; data_in = 2'b11; pop1 = 1'b1;
    #1;
    chk("sim.ready_in_full", ready_in, 0);
    chk("sim.full1_before", full1, 1);
    chk("sim.data_out1_before", data_out1, fill[0]);
    @(posedge clk);
    #1;
    chk("sim.full1_after", full1, 0);
    chk("sim.count1_after", count1, 1);
    chk("sim.data_out1_after", data_out1, fill[1]);
    @(negedge clk);
    idle();
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("sim.drain%0d.data_out1", i), data_out1, fill[i]);
      step(0, 0, 2'b00, 0, 1);
    end
    chk("sim.valid_out1_drained", valid_out1, 0);
    chk("sim.count1_drained", count1, 4);

    // Push to lane 0 while popping lane 1.
    step(1, 1, 2'b01, 0, 0);
    step(1, 0, 2'b10, 0, 1);
    chk("cross.valid_out0", valid_out0, 1);
    chk("cross.data_out0", data_out0, 2'b10);
    chk("cross.valid_out1", valid_out1, 0);
    chk("cross.count1", count1, 5);

    // Pop on empty lane 0 leaves the counter alone.
    step(0, 0, 2'b00, 1, 0);
    chk("empty.count0_first", count0, 11);
    chk("empty.valid_out0", valid_out0, 0);
    step(0, 0, 2'b00, 1, 0);
    chk("empty.count0_ignored", count0, 11);
    chk("empty.data_out0", data_out0, 0);

    // Asynchronous reset between edges with three words in lane 0.
    step(1, 0, 2'b01, 0, 0);
    step(1, 0, 2'b10, 0, 0);
    step(1, 0, 2'b11, 0, 0);
    chk("arst.valid_out0_before", valid_out0, 1);
    chk("arst.data_out0_before", data_out0, 2'b01);
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst.valid_out0_now", valid_out0, 0);
    chk("arst.data_out0_now", data_out0, 0);
    chk("arst.count0_now", count0, 0);
    chk("arst.count1_now", count1, 0);
    chk("arst.ready_in_now", ready_in, 1);
    #1;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.valid_out0_after", valid_out0, 0);
    chk("arst.full0_after", full0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
